// File: rtl/gpio_pkg.sv
// Shared GPIO constants: pin count, IO register map and debounce defaults.
// Latency: n/a (constants and helper function only).
// Backpressure: n/a.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  // Memory-mapped IO register addresses used by the IO block.
  localparam logic [31:0] IO_ENABLE_ADDR = 32'hFFFFFFFF;
  localparam logic [31:0] IO_OUTPUT_ADDR = 32'hFFFFFFFD;
  localparam logic [31:0] IO_INPUT_ADDR  = 32'hFFFFFFFC;

  // Debounce defaults: sample tick every DB_PRESCALE_DEF clocks,
  // DB_SAMPLES_DEF equal samples to accept a new level.
  localparam int DB_PRESCALE_DEF = 1000;
  localparam int DB_SAMPLES_DEF  = 4;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// GPIO conditioner bus: raw pads, enable/clear controls, debounced level, flags, irq.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/pulse, no handshake.
//   master : drives pad_in, enable_mask, edge_clr; observes IO_in, rise_flag, fall_flag, irq
//   slave  : the conditioner itself
interface gpio_input_conditioner_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] enable_mask;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] IO_in;
  logic [WIDTH-1:0] rise_flag;
  logic [WIDTH-1:0] fall_flag;
  logic             irq;

  modport master (
    output pad_in, enable_mask, edge_clr,
    input  IO_in, rise_flag, fall_flag, irq
  );

  modport slave (
    input  pad_in, enable_mask, edge_clr,
    output IO_in, rise_flag, fall_flag, irq
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One-pin synchroniser + tick-sampled history + debounced level.
// Latency: 2 sync flops, then level moves on the DB_SAMPLES-th equal tick sample.
// Backpressure: none.
//   clk, nrst : clock, async active-low reset
//   tick      : shared sample strobe from the prescaler
//   d         : raw asynchronous pad
//   level     : debounced level (registered)
//   rise/fall : level will go 0->1 / 1->0 at the coming clock edge
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                  r_s1;
  logic                  r_s2;
  // Only the newest DB_SAMPLES-1 samples are stored: together with the
  // current s2 they form the full DB_SAMPLES-wide window, and the oldest
  // bit would never be read again.
  logic [DB_SAMPLES-2:0] r_hist;
  logic                  r_level;

  logic [DB_SAMPLES-1:0] w_hist_nxt;
  logic                  w_all1;
  logic                  w_all0;

  assign w_hist_nxt = {r_hist, r_s2};
  assign w_all1     = &w_hist_nxt;
  assign w_all0     = ~|w_hist_nxt;

  // Edge events are decided from the new history, so the top can set its
  // flags in the same edge that the level changes.
  assign rise  = tick & w_all1 & ~r_level;
  assign fall  = tick & w_all0 &  r_level;
  assign level = r_level;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_hist  <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      if (tick) begin
        r_hist <= w_hist_nxt[DB_SAMPLES-2:0];
        if (rise)      r_level <= 1'b1;
        else if (fall) r_level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: sync + debounce every pad, sticky rise/fall flags, irq.
// Latency: pad step -> IO_in in 2+(DB_SAMPLES-1)*PRESCALE+1 .. 2+DB_SAMPLES*PRESCALE clks; irq +1.
// Backpressure: none; flags are sticky until write-1-to-clear on edge_clr.
//   clk, nrst : clock, async active-low reset
//   bus       : slave side of gpio_input_conditioner_if (pads, enable, clear, level, flags, irq)
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH      = GPIO_WIDTH,
  parameter int PRESCALE   = DB_PRESCALE_DEF,
  parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic                      clk,
  input  logic                      nrst,
  gpio_input_conditioner_if.slave   bus
);

  localparam int CW = cnt_width(PRESCALE);

  logic [CW-1:0]    r_cnt;
  logic             w_tick;

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  logic [WIDTH-1:0] r_rise_flag;
  logic [WIDTH-1:0] r_fall_flag;
  logic             r_irq;

  // Shared prescaler: tick in the last count of each period. With
  // PRESCALE=1 the counter sits at 0 and tick is permanently high.
  assign w_tick = (r_cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_debounce_bit #(
      .DB_SAMPLES (DB_SAMPLES)
    ) u_db (
      .clk   (clk),
      .nrst  (nrst),
      .tick  (w_tick),
      .d     (bus.pad_in[g]),
      .level (w_level[g]),
      .rise  (w_rise[g]),
      .fall  (w_fall[g])
    );
  end

  // Set has priority over a simultaneous clear; a zero enable bit only
  // stops new sets and leaves an already-latched flag alone.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rise_flag <= '0;
      r_fall_flag <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_rise_flag <= (r_rise_flag & ~bus.edge_clr) | (w_rise & bus.enable_mask);
      r_fall_flag <= (r_fall_flag & ~bus.edge_clr) | (w_fall & bus.enable_mask);
      r_irq       <= |(r_rise_flag | r_fall_flag);
    end
  end

  assign bus.IO_in     = w_level;
  assign bus.rise_flag = r_rise_flag;
  assign bus.fall_flag = r_fall_flag;
  assign bus.irq       = r_irq;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
module tb_gpio_input_conditioner;
  import gpio_pkg::*;

  localparam int W   = 32;
  localparam int PS  = 4;
  localparam int DBS = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b1;

  gpio_input_conditioner_if #(.WIDTH(W)) bus();

  gpio_input_conditioner #(
    .WIDTH      (W),
    .PRESCALE   (PS),
    .DB_SAMPLES (DBS)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release (first edge after release is 1).
  int cyc_cnt = 0;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc_cnt <= 0;
    else       cyc_cnt <= cyc_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] io;
    logic [31:0] rise;
    logic [31:0] fall;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int v, input int lo, input int hi);
    n_assert++;
    assert ((v >= lo && v <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic sb_push(input logic [31:0] io, input logic [31:0] rise, input logic [31:0] fall);
    exp_t e;
    e.io = io; e.rise = rise; e.fall = fall;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_io"},   bus.IO_in,     e.io);
      check({tag, "_rise"}, bus.rise_flag, e.rise);
      check({tag, "_fall"}, bus.fall_flag, e.fall);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until (IO_in & mask) == val; returns cycles taken, or maxc+1 on timeout.
  task automatic wait_io(input logic [31:0] mask, input logic [31:0] val,
                         input int maxc, output int ncyc);
    ncyc = maxc + 1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if ((bus.IO_in & mask) === val) begin
        ncyc = i;
        break;
      end
    end
  endtask

  task automatic clear_flags(input logic [31:0] m);
    bus.edge_clr = m;
    cycles(1);
    bus.edge_clr = '0;
  endtask

  initial begin
    int n;
    int t_rel;
    int m;
    int acc;
    int guard;
    logic g_io, g_rise, g_irq;

    bus.pad_in      = '0;
    bus.enable_mask = '1;
    bus.edge_clr    = '0;

    // 1: async reset between clock edges, pads all high
    #23;
    bus.pad_in = '1;
    nrst       = 1'b0;
    #1;
    check("rst_io",   bus.IO_in,     32'h0);
    check("rst_rise", bus.rise_flag, 32'h0);
    check("rst_fall", bus.fall_flag, 32'h0);
    check("rst_irq",  32'(bus.irq),  32'h0);
    #23;
    nrst = 1'b1;
    sb_push(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    wait_io(32'hFFFFFFFF, 32'hFFFFFFFF, 20, n);
    check_range("rst_lat", n, 11, 14);
    sb_check("rst");
    check("rst_irq_lag", 32'(bus.irq), 32'h0);
    t_rel = cyc_cnt;
    cycles(1);
    check("rst_irq_set", 32'(bus.irq), 32'h1);
    clear_flags(32'hFFFFFFFF);
    check("clr_all_rise", bus.rise_flag, 32'h0);
    cycles(1);
    check("clr_all_irq", 32'(bus.irq), 32'h0);

    // 6: all pins fall together
    bus.pad_in = '0;
    sb_push(32'h0, 32'h0, 32'hFFFFFFFF);
    wait_io(32'hFFFFFFFF, 32'h0, 20, n);
    check_range("mfall_lat", n, 11, 14);
    sb_check("mfall");
    check("mfall_wrap", 32'((cyc_cnt - t_rel) % 4), 32'h0);
    clear_flags(32'hFFFFFFFF);
    cycles(1);
    check("mfall_irq_clr", 32'(bus.irq), 32'h0);

    // 2: clean step on pin 0
    bus.pad_in[0] = 1'b1;
    sb_push(32'h1, 32'h1, 32'h0);
    wait_io(32'h1, 32'h1, 20, n);
    check_range("step_lat", n, 11, 14);
    sb_check("step");
    check("step_irq_lag", 32'(bus.irq), 32'h0);
    cycles(1);
    check("step_irq", 32'(bus.irq), 32'h1);

    // 4a: clear on an idle cycle
    cycles(3);
    clear_flags(32'h1);
    check("clr0_rise", bus.rise_flag, 32'h0);
    cycles(1);
    check("clr0_irq", 32'(bus.irq), 32'h0);

    // 3: 5-cycle glitch on pin 5 must be rejected
    g_io = 1'b0; g_rise = 1'b0; g_irq = 1'b0;
    bus.pad_in[5] = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) bus.pad_in[5] = 1'b0;
      cycles(1);
      g_io   = g_io   | bus.IO_in[5];
      g_rise = g_rise | bus.rise_flag[5];
      g_irq  = g_irq  | bus.irq;
    end
    check("glitch_io",   32'(g_io),   32'h0);
    check("glitch_rise", 32'(g_rise), 32'h0);
    check("glitch_irq",  32'(g_irq),  32'h0);

    // 4b: clear on pin 3 in the very cycle its rise is accepted.
    // Pad changed after edge m reaches s2 for tick edges >= m+3; ticks on
    // edges that are multiples of PS; acceptance DBS-1 ticks later.
    bus.pad_in[3] = 1'b1;
    m   = cyc_cnt;
    acc = ((m + 3 + PS - 1) / PS) * PS + (DBS - 1) * PS;
    guard = 0;
    while (cyc_cnt < acc - 1 && guard < 40) begin
      cycles(1);
      guard++;
    end
    bus.edge_clr[3] = 1'b1;
    sb_push(32'h9, 32'h8, 32'h0);
    cycles(1);
    bus.edge_clr = '0;
    check("setwin_cyc", 32'(cyc_cnt), 32'(acc));
    sb_check("setwin");

    // 5: enable mask only allows pins 4..7
    clear_flags(32'hFFFFFFFF);
    bus.pad_in[3] = 1'b0;
    sb_push(32'h1, 32'h0, 32'h8);
    wait_io(32'h8, 32'h0, 20, n);
    sb_check("p3_fall");
    clear_flags(32'hFFFFFFFF);
    bus.enable_mask = 32'h0000_00F0;
    bus.pad_in[3]   = 1'b1;
    bus.pad_in[4]   = 1'b1;
    sb_push(32'h19, 32'h10, 32'h0);
    wait_io(32'h18, 32'h18, 20, n);
    check_range("mask_lat", n, 11, 14);
    sb_check("mask");

    // mask=0 blocks new sets but keeps existing flags
    bus.enable_mask = '0;
    bus.pad_in[4]   = 1'b0;
    sb_push(32'h09, 32'h10, 32'h0);
    wait_io(32'h10, 32'h0, 20, n);
    sb_check("mask0");
    cycles(1);
    check("mask0_irq", 32'(bus.irq), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
